// File: rtl/line_normalizer.sv
// line_normalizer: forces every active video line to exactly H_DISP pixels.
// Short lines are padded with fill_color right behind the real pixels, long
// lines are optionally cropped, and per-line status pulses plus a per-frame
// line counter are reported. With EN low the block is a plain registered bypass.
module line_normalizer #(
   parameter int DATA_W = 24,
   parameter int H_DISP = 1280,
   parameter int CNT_W  = 12,
   parameter int LCNT_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EN,
   input  logic              CROP_EN,
   input  logic [DATA_W-1:0] fill_color,
   input  logic              pre_vs,
   input  logic              pre_de,
   input  logic [DATA_W-1:0] pre_data,
   output logic              post_vs,
   output logic              post_de,
   output logic [DATA_W-1:0] post_data,
   output logic [LCNT_W-1:0] line_cnt,
   output logic              short_pls,
   output logic              long_pls,
   output logic              ovr_pls
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RECV = 2'd1;
   localparam logic [1:0] FILL = 2'd2;
   localparam logic [1:0] DROP = 2'd3;

   // Line length target, kept at counter width so compares never widen.
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_DISP);
   // A one-pixel line is already complete after its first pixel.
   localparam logic [1:0] FIRST_NEXT = (H_DISP == 1) ? DROP : RECV;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
   logic              long_seen_q, long_seen_d;
   logic              vs_q, vs_d;
   logic              de_q, de_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              short_q, short_d;
   logic              long_q, long_d;
   logic              ovr_q, ovr_d;

   logic [CNT_W-1:0]  cnt_inc;
   logic [LCNT_W-1:0] line_cnt_inc;

   assign cnt_inc      = cnt_q + CNT_W'(1);
   // Line counter saturates at all-ones rather than wrapping.
   assign line_cnt_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + LCNT_W'(1);

   // Next-state and next-output computation for the line state machine.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_cnt_d  = line_cnt_q;
      long_seen_d = long_seen_q;
      vs_d        = pre_vs;
      de_d        = 1'b0;
      data_d      = '0;
      short_d     = 1'b0;
      long_d      = 1'b0;
      ovr_d       = 1'b0;

      if (!EN) begin
         // Bypass: data is still zeroed outside active video.
         de_d    = pre_de;
         data_d  = pre_de ? pre_data : '0;
         state_d = IDLE;
      end else if (pre_vs) begin
         // Frame start wins over everything, including an unfinished fill.
         state_d    = IDLE;
         cnt_d      = '0;
         line_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pre_de) begin
                  de_d        = 1'b1;
                  data_d      = pre_data;
                  cnt_d       = CNT_W'(1);
                  line_cnt_d  = line_cnt_inc;
                  long_seen_d = 1'b0;
                  state_d     = FIRST_NEXT;
               end
            end
            RECV: begin
               de_d  = 1'b1;
               cnt_d = cnt_inc;
               if (pre_de) begin
                  data_d = pre_data;
                  if (cnt_inc == H_LAST) state_d = DROP;
               end else begin
                  // Line ended early: start padding this very cycle.
                  data_d  = fill_color;
                  short_d = 1'b1;
                  state_d = (cnt_inc == H_LAST) ? IDLE : FILL;
               end
            end
            FILL: begin
               de_d = 1'b1;
               if (pre_de) begin
                  // New line arrived before padding finished: abandon the pad.
                  ovr_d      = 1'b1;
                  data_d     = pre_data;
                  cnt_d      = CNT_W'(1);
                  line_cnt_d = line_cnt_inc;
                  state_d    = FIRST_NEXT;
               end else begin
                  data_d = fill_color;
                  cnt_d  = cnt_inc;
                  if (cnt_inc == H_LAST) state_d = IDLE;
               end
            end
            default: begin // DROP
               if (pre_de) begin
                  long_seen_d = 1'b1;
                  long_d      = !long_seen_q;
                  if (!CROP_EN) begin
                     de_d   = 1'b1;
                     data_d = pre_data;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   // State and registered outputs; asynchronous reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         line_cnt_q  <= '0;
         long_seen_q <= 1'b0;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         data_q      <= '0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         line_cnt_q  <= line_cnt_d;
         long_seen_q <= long_seen_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         data_q      <= data_d;
         short_q     <= short_d;
         long_q      <= long_d;
         ovr_q       <= ovr_d;
      end
   end

   assign post_vs   = vs_q;
   assign post_de   = de_q;
   assign post_data = data_q;
   assign line_cnt  = line_cnt_q;
   assign short_pls = short_q;
   assign long_pls  = long_q;
   assign ovr_pls   = ovr_q;

endmodule

// File: tb/tb_line_normalizer.sv
// Testbench for line_normalizer: expected output beats are queued as the
// stimulus is driven and compared by a monitor one clock later.
module tb_line_normalizer;

   localparam int DW = 24;
   localparam int H  = 16;
   localparam int LW = 11;
   localparam logic [DW-1:0] FILLC = 24'h00FF00;

   typedef struct {
      logic          vs;
      logic          de;
      logic [DW-1:0] data;
      logic          sh;
      logic          lo;
      logic          ov;
      logic [LW-1:0] lc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b1;
   logic          crop_en = 1'b1;
   logic [DW-1:0] fill_color = FILLC;
   logic          pre_vs = 1'b0;
   logic          pre_de = 1'b0;
   logic [DW-1:0] pre_data = '0;
   logic          post_vs, post_de, short_pls, long_pls, ovr_pls;
   logic [DW-1:0] post_data;
   logic [LW-1:0] line_cnt;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_lc = 0;

   line_normalizer #(.DATA_W(DW), .H_DISP(H), .CNT_W(12), .LCNT_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .EN(en), .CROP_EN(crop_en), .fill_color(fill_color),
      .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
      .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
      .line_cnt(line_cnt), .short_pls(short_pls), .long_pls(long_pls), .ovr_pls(ovr_pls)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
      end
   endtask

   // Monitor: compare the beat produced by the stimulus of the previous cycle.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("vs", 32'(post_vs), 32'(e.vs));
         check_eq("de", 32'(post_de), 32'(e.de));
         check_eq("data", 32'(post_data), 32'(e.data));
         check_eq("pulses", 32'({short_pls, long_pls, ovr_pls}), 32'({e.sh, e.lo, e.ov}));
         check_eq("line_cnt", 32'(line_cnt), 32'(e.lc));
      end
   end

   task automatic drive(input logic vs, input logic de, input logic [DW-1:0] d, input exp_t e);
      @(negedge clk);
      pre_vs   = vs;
      pre_de   = de;
      pre_data = d;
      exp_q.push_back(e);
   endtask

   function automatic exp_t mk(input logic vs, input logic de, input logic [DW-1:0] d,
                               input logic sh, input logic lo, input logic ov);
      exp_t e;
      e.vs = vs; e.de = de; e.data = de ? d : '0;
      e.sh = sh; e.lo = lo; e.ov = ov; e.lc = LW'(exp_lc);
      return e;
   endfunction

   task automatic vsync();
      exp_lc = 0;
      drive(1'b1, 1'b0, '0, mk(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0));
      drive(1'b0, 1'b0, '0, mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
   endtask

   // One line of n pixels followed by blank cycles, normalising mode.
   task automatic run_line(input int n, input int blank, input logic crop, input logic [7:0] tag);
      int outlen;
      logic [DW-1:0] pix;
      crop_en = crop;
      outlen = (n < H) ? H : (crop ? H : n);
      for (int i = 0; i < n + blank; i++) begin
         pix = {tag, 16'(i + 1)};
         if (i == 0 && exp_lc < (1 << LW) - 1) exp_lc++;
         drive(1'b0, i < n, (i < n) ? pix : '0,
               mk(1'b0, i < outlen, (i < n) ? pix : FILLC,
                  (n < H) && (i == n), (n > H) && (i == H), 1'b0));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] pix;
      // Reset state
      #12;
      check_eq("rst_de", 32'(post_de), 0);
      check_eq("rst_vs", 32'(post_vs), 0);
      check_eq("rst_data", 32'(post_data), 0);
      check_eq("rst_lc", 32'(line_cnt), 0);
      check_eq("rst_pls", 32'({short_pls, long_pls, ovr_pls}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exact, short, long-crop, long-pass lines
      vsync(); run_line(16, 4, 1'b1, 8'h11);
      vsync(); run_line(10, 20, 1'b1, 8'h22);
      vsync(); run_line(20, 5, 1'b1, 8'h33);
      vsync(); run_line(20, 5, 1'b0, 8'h44);
      crop_en = 1'b1;

      // Overrun: 10 pixels, 3 blank, 16-pixel line
      vsync();
      for (int i = 0; i < 39; i++) begin
         if (i < 10) pix = 24'h550000 + 24'(i + 1);
         else if (i >= 13 && i < 29) pix = 24'h660000 + 24'(i);
         else pix = '0;
         if (i == 0 || i == 13) exp_lc++;
         drive(1'b0, (i < 10) || (i >= 13 && i < 29), pix,
               mk(1'b0, i < 29, (i < 10 || i >= 13) ? pix : FILLC, i == 10, 1'b0, i == 13));
      end

      // vs during fill: 4 pixels, pre_vs two cycles after the line ends
      vsync();
      for (int i = 0; i < 8; i++) begin
         pix = 24'h770000 + 24'(i + 1);
         if (i == 0) exp_lc = 1;
         if (i == 5) exp_lc = 0;
         drive(i == 5, i < 4, (i < 4) ? pix : '0,
               mk(i == 5, i < 5, (i < 4) ? pix : FILLC, i == 4, 1'b0, 1'b0));
      end
      run_line(4, 14, 1'b1, 8'h88);

      // Bypass: 10 pixels pass through untouched, line count holds
      en = 1'b0;
      for (int i = 0; i < 14; i++) begin
         pix = 24'h990000 + 24'(i + 1);
         drive(1'b0, i < 10, (i < 10) ? pix : '0, mk(1'b0, i < 10, pix, 1'b0, 1'b0, 1'b0));
      end

      // Asynchronous reset in the middle of a bypassed line
      for (int i = 0; i < 5; i++) begin
         pix = 24'hAA0000 + 24'(i + 1);
         drive(1'b0, 1'b1, pix, mk(1'b0, 1'b1, pix, 1'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
      pre_de = 1'b1;
      pre_data = 24'hAA0006;
      rst_n = 1'b0;
      #1;
      check_eq("arst_de", 32'(post_de), 0);
      check_eq("arst_data", 32'(post_data), 0);
      check_eq("arst_lc", 32'(line_cnt), 0);
      @(negedge clk);
      pre_de = 1'b0;
      pre_data = '0;
      en = 1'b1;
      rst_n = 1'b1;
      exp_lc = 0;
      run_line(16, 4, 1'b1, 8'hBB);

      @(posedge clk);
      #2;
      check_eq("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
